// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus device responder.
package hyperbus_pkg;

  // 48-bit command/address word, first byte on the wire lands in rw/as/burst.
  typedef struct packed {
    logic        rw;       // 1 = read, 0 = write
    logic        as;       // 1 = register space, 0 = memory space
    logic        burst;    // 1 = linear, 0 = wrapped
    logic [28:0] addr_hi;
    logic [12:0] rsvd;
    logic [2:0]  addr_lo;
  } hyper_ca_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LATENCY,
    ST_RD,
    ST_WR,
    ST_REG_WR,
    ST_DONE
  } dev_state_e;

  localparam logic [11:0] RegAddrId0 = 12'h000;
  localparam logic [11:0] RegAddrCr0 = 12'h800;

  // Word-address mask of the wrap group selected by CR0[1:0].
  function automatic logic [5:0] wrap_mask(input logic [1:0] burst_len);
    case (burst_len)
      2'b00:   return 6'd63;  // 64 words
      2'b01:   return 6'd31;  // 32 words
      2'b10:   return 6'd7;   // 8 words
      default: return 6'd15;  // 16 words
    endcase
  endfunction

endpackage

// File: rtl/hyperbus_dev_mem.sv
// Single-port backing store: byte-enabled synchronous write, combinational read.
module hyperbus_dev_mem #(
  parameter int MemWords = 1024,
  parameter int AW       = $clog2(MemWords)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [MemWords];

  // Byte-lane write; be_i[1] covers the high byte, be_i[0] the low byte.
  always_ff @(posedge clk_i) begin
    if (we_i && be_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    if (we_i && be_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/hyperbus_dev_responder.sv
// HyperBus device end: CA decode, initial latency, memory/register read and write.
module hyperbus_dev_responder
  import hyperbus_pkg::*;
#(
  parameter int          MemWords      = 1024,
  parameter int          LatencyClocks = 6,
  parameter logic [15:0] Id0Value      = 16'h0C81,
  parameter logic [15:0] Cr0Reset      = 16'h8F1F
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hyper_reset_ni,
  input  logic       hyper_cs_ni,
  input  logic       hyper_ck_i,
  input  logic [7:0] hyper_dq_i,
  output logic [7:0] hyper_dq_o,
  output logic       hyper_dq_oe_o,
  input  logic       hyper_rwds_i,
  output logic       hyper_rwds_o,
  output logic       hyper_rwds_oe_o
);

  localparam int AW = $clog2(MemWords);
  // Terminal counts for the latency phase (edges minus one).
  localparam logic [7:0] LatLastSingle = 8'(2 * LatencyClocks - 1);
  localparam logic [7:0] LatLastDouble = 8'(4 * LatencyClocks - 1);
  localparam logic [31:0] AddrId0 = {20'd0, RegAddrId0};
  localparam logic [31:0] AddrCr0 = {20'd0, RegAddrCr0};

  dev_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        byte_q, byte_d;       // 0 = next byte is [15:8], 1 = [7:0]
  logic [39:0] ca_q, ca_d;           // first five CA bytes
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        reg_q, reg_d;
  logic        lin_q, lin_d;
  logic [7:0]  wbuf_q, wbuf_d;
  logic        wmask_q, wmask_d;
  logic [15:0] cr0_q, cr0_d;
  logic [7:0]  dq_o_q, dq_o_d;
  logic        dq_oe_q, dq_oe_d;
  logic        rwds_o_q, rwds_o_d;
  logic        rwds_oe_q, rwds_oe_d;
  logic        ck_q, cs_q;

  logic        rst;
  logic        ck_edge;
  hyper_ca_t   ca_n;
  logic        unused_rsvd;
  logic [7:0]  lat_last;
  logic [5:0]  wmask6;
  logic [31:0] addr_next;
  logic [15:0] mem_rdata;
  logic [15:0] rd_word;
  logic        mem_we;
  logic [1:0]  mem_be;

  assign rst         = rst_i | ~hyper_reset_ni;
  assign ck_edge     = (hyper_ck_i != ck_q) && !hyper_cs_ni;
  assign ca_n        = hyper_ca_t'({ca_q, hyper_dq_i});
  assign unused_rsvd = ^ca_n.rsvd;
  assign lat_last    = cr0_q[3] ? LatLastDouble : LatLastSingle;
  assign wmask6      = wrap_mask(cr0_q[1:0]);
  assign addr_next   = lin_q ? addr_q + 32'd1
                             : {addr_q[31:6], (addr_q[5:0] & ~wmask6) |
                                              ((addr_q[5:0] + 6'd1) & wmask6)};

  // Read source: register file in register space, backing memory otherwise.
  always_comb begin
    rd_word = mem_rdata;
    if (reg_q) begin
      if (addr_q == AddrId0)      rd_word = Id0Value;
      else if (addr_q == AddrCr0) rd_word = cr0_q;
      else                        rd_word = 16'h0000;
    end
  end

  hyperbus_dev_mem #(
    .MemWords (MemWords),
    .AW       (AW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we & ~rst),
    .be_i    (mem_be),
    .addr_i  (addr_q[AW-1:0]),
    .wdata_i ({wbuf_q, hyper_dq_i}),
    .rdata_o (mem_rdata)
  );

  // Next-state and next-output computation; CS high overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    ca_d      = ca_q;
    addr_d    = addr_q;
    rd_d      = rd_q;
    reg_d     = reg_q;
    lin_d     = lin_q;
    wbuf_d    = wbuf_q;
    wmask_d   = wmask_q;
    cr0_d     = cr0_q;
    dq_o_d    = dq_o_q;
    dq_oe_d   = dq_oe_q;
    rwds_o_d  = rwds_o_q;
    rwds_oe_d = rwds_oe_q;
    mem_we    = 1'b0;
    mem_be    = 2'b00;
    if (hyper_cs_ni) begin
      state_d   = ST_IDLE;
      cnt_d     = 8'd0;
      byte_d    = 1'b0;
      dq_o_d    = 8'd0;
      dq_oe_d   = 1'b0;
      rwds_o_d  = 1'b0;
      rwds_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_q) begin
            state_d   = ST_CA;
            cnt_d     = 8'd0;
            rwds_oe_d = 1'b1;
            rwds_o_d  = cr0_q[3];
          end
        end
        ST_CA: begin
          if (ck_edge) begin
            ca_d  = {ca_q[31:0], hyper_dq_i};
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == 8'd5) begin
              cnt_d     = 8'd0;
              byte_d    = 1'b0;
              rwds_oe_d = 1'b0;
              rwds_o_d  = 1'b0;
              addr_d    = {ca_n.addr_hi, ca_n.addr_lo};
              rd_d      = ca_n.rw;
              reg_d     = ca_n.as;
              lin_d     = ca_n.burst;
              state_d   = (!ca_n.rw && ca_n.as) ? ST_REG_WR : ST_LATENCY;
            end
          end
        end
        ST_LATENCY: begin
          if (ck_edge) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == lat_last) begin
              cnt_d   = 8'd0;
              state_d = rd_q ? ST_RD : ST_WR;
              if (rd_q) begin
                dq_oe_d   = 1'b1;
                rwds_oe_d = 1'b1;
                dq_o_d    = 8'd0;
                rwds_o_d  = 1'b0;
              end
            end
          end
        end
        ST_RD: begin
          if (ck_edge) begin
            if (!byte_q) begin
              dq_o_d   = rd_word[15:8];
              rwds_o_d = 1'b1;
              byte_d   = 1'b1;
            end else begin
              dq_o_d   = rd_word[7:0];
              rwds_o_d = 1'b0;
              byte_d   = 1'b0;
              addr_d   = addr_next;
            end
          end
        end
        ST_WR: begin
          if (ck_edge) begin
            if (!byte_q) begin
              wbuf_d  = hyper_dq_i;
              wmask_d = hyper_rwds_i;
              byte_d  = 1'b1;
            end else begin
              mem_we = 1'b1;
              mem_be = {~wmask_q, ~hyper_rwds_i};
              byte_d = 1'b0;
              addr_d = addr_next;
            end
          end
        end
        ST_REG_WR: begin
          if (ck_edge) begin
            if (!byte_q) begin
              wbuf_d = hyper_dq_i;
              byte_d = 1'b1;
            end else begin
              if (addr_q == AddrCr0) cr0_d = {wbuf_q, hyper_dq_i};
              byte_d  = 1'b0;
              state_d = ST_DONE;
            end
          end
        end
        default: ;  // ST_DONE: hold until CS rises
      endcase
    end
  end

  // Control state and registered outputs, cleared by either reset source.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 8'd0;
      byte_q    <= 1'b0;
      addr_q    <= 32'd0;
      rd_q      <= 1'b0;
      reg_q     <= 1'b0;
      lin_q     <= 1'b0;
      cr0_q     <= Cr0Reset;
      dq_o_q    <= 8'd0;
      dq_oe_q   <= 1'b0;
      rwds_o_q  <= 1'b0;
      rwds_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      reg_q     <= reg_d;
      lin_q     <= lin_d;
      cr0_q     <= cr0_d;
      dq_o_q    <= dq_o_d;
      dq_oe_q   <= dq_oe_d;
      rwds_o_q  <= rwds_o_d;
      rwds_oe_q <= rwds_oe_d;
    end
  end

  // Datapath holding registers and input trackers; no reset needed.
  always_ff @(posedge clk_i) begin
    ca_q    <= ca_d;
    wbuf_q  <= wbuf_d;
    wmask_q <= wmask_d;
    ck_q    <= hyper_ck_i;
    cs_q    <= hyper_cs_ni;
  end

  assign hyper_dq_o      = dq_o_q;
  assign hyper_dq_oe_o   = dq_oe_q;
  assign hyper_rwds_o    = rwds_o_q;
  assign hyper_rwds_oe_o = rwds_oe_q;

endmodule

// File: tb/tb_hyperbus_dev_responder.sv
// Directed bench: host-side HyperBus transactions against the device responder.
module tb_hyperbus_dev_responder;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       hyper_reset_ni;
  logic       cs_n;
  logic       ck;
  logic [7:0] dq_i;
  logic       rwds_i;
  logic [7:0] dq_o;
  logic       dq_oe;
  logic       rwds_o;
  logic       rwds_oe;

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0]  s_dq;
  logic        s_dq_oe, s_rwds, s_rwds_oe;
  logic [15:0] w;

  hyperbus_dev_responder dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .hyper_reset_ni  (hyper_reset_ni),
    .hyper_cs_ni     (cs_n),
    .hyper_ck_i      (ck),
    .hyper_dq_i      (dq_i),
    .hyper_dq_o      (dq_o),
    .hyper_dq_oe_o   (dq_oe),
    .hyper_rwds_i    (rwds_i),
    .hyper_rwds_o    (rwds_o),
    .hyper_rwds_oe_o (rwds_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] mk_ca(input logic rw, input logic as, input logic bt,
                                        input logic [31:0] a);
    return {rw, as, bt, a[31:3], 13'd0, a[2:0]};
  endfunction

  // One hyper_ck edge carrying a byte; outputs sampled one clk later.
  task automatic bus_edge(input logic [7:0] d, input logic rw);
    dq_i   = d;
    rwds_i = rw;
    ck     = ~ck;
    @(negedge clk);
    s_dq      = dq_o;
    s_dq_oe   = dq_oe;
    s_rwds    = rwds_o;
    s_rwds_oe = rwds_oe;
    @(negedge clk);
  endtask

  task automatic start(input logic [47:0] ca, input int lat, input logic exp_ca_rwds);
    cs_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      bus_edge(ca[47-8*i -: 8], 1'b0);
      if (i == 0) begin
        chk("ca_rwds_oe", s_rwds_oe, 1);
        chk("ca_rwds", s_rwds, exp_ca_rwds);
      end
    end
    chk("ca_end_rwds_oe", s_rwds_oe, 0);
    for (int i = 0; i < lat; i++) begin
      bus_edge(8'h00, 1'b0);
      if (i == lat - 2) chk("lat_pre_dq_oe", s_dq_oe, 0);
    end
    if (lat > 0) chk("lat_end_dq_oe", s_dq_oe, ca[47]);
  endtask

  task automatic rd_word(output logic [15:0] word);
    logic [7:0] b1;
    bus_edge(8'h00, 1'b0);
    b1 = s_dq;
    chk("rd_rwds_first", s_rwds, 1);
    bus_edge(8'h00, 1'b0);
    chk("rd_rwds_second", s_rwds, 0);
    word = {b1, s_dq};
  endtask

  task automatic wr_word(input logic [15:0] word, input logic [1:0] m);
    bus_edge(word[15:8], m[1]);
    bus_edge(word[7:0], m[0]);
  endtask

  task automatic finish_txn();
    cs_n = 1'b1;
    @(negedge clk);
    chk("end_dq_oe", dq_oe, 0);
    chk("end_rwds_oe", rwds_oe, 0);
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; hyper_reset_ni = 1'b1; cs_n = 1'b1; ck = 1'b0;
    dq_i = 8'h00; rwds_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dq_o", dq_o, 0);
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_rwds_o", rwds_o, 0);
    chk("rst_rwds_oe", rwds_oe, 0);
    rst_i = 1'b0;
    @(negedge clk);

    // ID0 read, CR0 at reset: double latency (24 edges), RWDS high in CA.
    start(mk_ca(1, 1, 0, 32'h000), 24, 1'b1);
    rd_word(w); chk("id0", w, 16'h0C81);
    finish_txn();

    // CR0 = 8F14: single latency (12 edges), RWDS low in CA.
    start(mk_ca(0, 1, 1, 32'h800), 0, 1'b1);
    wr_word(16'h8F14, 2'b00);
    finish_txn();
    start(mk_ca(1, 1, 1, 32'h800), 12, 1'b0);
    rd_word(w); chk("cr0_8f14", w, 16'h8F14);
    finish_txn();

    // CR0 = 8F16: single latency, 8-word wrap. Preload word i = i.
    start(mk_ca(0, 1, 1, 32'h800), 0, 1'b0);
    wr_word(16'h8F16, 2'b00);
    finish_txn();
    start(mk_ca(0, 0, 1, 32'h000), 12, 1'b0);
    for (int i = 0; i < 16; i++) wr_word(16'(i), 2'b00);
    finish_txn();
    start(mk_ca(1, 0, 0, 32'h006), 12, 1'b0);
    rd_word(w); chk("wrap8_0", w, 16'h0006);
    rd_word(w); chk("wrap8_1", w, 16'h0007);
    rd_word(w); chk("wrap8_2", w, 16'h0000);
    rd_word(w); chk("wrap8_3", w, 16'h0001);
    finish_txn();

    // Back to 8F1F: double latency, 16-word wrap.
    start(mk_ca(0, 1, 1, 32'h800), 0, 1'b0);
    wr_word(16'h8F1F, 2'b00);
    finish_txn();
    start(mk_ca(1, 0, 0, 32'h00E), 24, 1'b1);
    rd_word(w); chk("wrap16_0", w, 16'h000E);
    rd_word(w); chk("wrap16_1", w, 16'h000F);
    rd_word(w); chk("wrap16_2", w, 16'h0000);
    rd_word(w); chk("wrap16_3", w, 16'h0001);
    finish_txn();

    // Linear write/read across the top of memory.
    start(mk_ca(0, 0, 1, 32'h3FE), 24, 1'b1);
    wr_word(16'h1111, 2'b00); wr_word(16'h2222, 2'b00);
    wr_word(16'h3333, 2'b00); wr_word(16'h4444, 2'b00);
    finish_txn();
    start(mk_ca(1, 0, 1, 32'h3FE), 24, 1'b1);
    rd_word(w); chk("lin_0", w, 16'h1111);
    rd_word(w); chk("lin_1", w, 16'h2222);
    rd_word(w); chk("lin_2", w, 16'h3333);
    rd_word(w); chk("lin_3", w, 16'h4444);
    finish_txn();
    start(mk_ca(1, 0, 1, 32'h000), 24, 1'b1);
    rd_word(w); chk("lin_wrap_mem0", w, 16'h3333);
    finish_txn();

    // Byte mask on the low byte of word 5.
    start(mk_ca(0, 0, 1, 32'h005), 24, 1'b1);
    wr_word(16'h0000, 2'b00);
    finish_txn();
    start(mk_ca(0, 0, 1, 32'h005), 24, 1'b1);
    wr_word(16'hABCD, 2'b01);
    finish_txn();
    start(mk_ca(1, 0, 1, 32'h005), 24, 1'b1);
    rd_word(w); chk("masked_wr", w, 16'hAB00);
    finish_txn();

    // CS raised after three data bytes.
    start(mk_ca(1, 0, 1, 32'h3FE), 24, 1'b1);
    bus_edge(8'h00, 1'b0);
    bus_edge(8'h00, 1'b0);
    bus_edge(8'h00, 1'b0);
    chk("abort_byte3", s_dq, 8'h22);
    finish_txn();

    // rst_i pulse mid-read.
    start(mk_ca(1, 0, 1, 32'h3FE), 24, 1'b1);
    bus_edge(8'h00, 1'b0);
    chk("pre_rst_byte", s_dq, 8'h11);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mid_rst_dq_oe", dq_oe, 0);
    chk("mid_rst_rwds_oe", rwds_oe, 0);
    chk("mid_rst_dq_o", dq_o, 0);
    bus_edge(8'h00, 1'b0);
    chk("post_rst_idle_dq_oe", s_dq_oe, 0);
    finish_txn();
    start(mk_ca(1, 1, 0, 32'h000), 24, 1'b1);
    rd_word(w); chk("id0_after_rst", w, 16'h0C81);
    finish_txn();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
